// File: rtl/tl_periph_demux.sv
// TileLink-UL 1-to-N peripheral demultiplexer.
// Registers one master A request, decodes its address into a slave index and
// issues it to that slave. D responses are muxed back from the current target
// only. Addresses with nonzero bits above the slave index are answered
// locally by an error responder with a denied response.
// Ports:
//   xbar_clock_i / xbar_reset_i : clock, synchronous active-high reset
//   m_a_* / m_d_*               : master-side A request and D response channels
//   s_a_*                       : A payload broadcast to all slaves, one-hot s_a_valid
//   s_d_*                       : flattened per-slave D channels (slave k at slice k)
module tl_periph_demux #(
    parameter int unsigned TL_RS   = 4,
    parameter int unsigned TL_AW   = 32,
    parameter int unsigned N       = 4,
    parameter int unsigned OFF_AW  = 1,
    parameter int unsigned MAX_OUT = 4
) (
    input  logic                 xbar_clock_i,
    input  logic                 xbar_reset_i,

    input  logic [2:0]           m_a_opcode,
    input  logic [2:0]           m_a_param,
    input  logic [3:0]           m_a_size,
    input  logic [TL_RS-1:0]     m_a_source,
    input  logic [TL_AW-1:0]     m_a_address,
    input  logic [3:0]           m_a_mask,
    input  logic [31:0]          m_a_data,
    input  logic                 m_a_valid,
    output logic                 m_a_ready,

    output logic [2:0]           m_d_opcode,
    output logic [1:0]           m_d_param,
    output logic [3:0]           m_d_size,
    output logic [TL_RS-1:0]     m_d_source,
    output logic                 m_d_denied,
    output logic [31:0]          m_d_data,
    output logic                 m_d_corrupt,
    output logic                 m_d_valid,
    input  logic                 m_d_ready,

    output logic [2:0]           s_a_opcode,
    output logic [2:0]           s_a_param,
    output logic [3:0]           s_a_size,
    output logic [TL_RS-1:0]     s_a_source,
    output logic [3:0]           s_a_mask,
    output logic [31:0]          s_a_data,
    output logic [OFF_AW-1:0]    s_a_address,
    output logic [N-1:0]         s_a_valid,
    input  logic [N-1:0]         s_a_ready,

    input  logic [N*3-1:0]       s_d_opcode,
    input  logic [N*2-1:0]       s_d_param,
    input  logic [N*4-1:0]       s_d_size,
    input  logic [N*TL_RS-1:0]   s_d_source,
    input  logic [N-1:0]         s_d_denied,
    input  logic [N*32-1:0]      s_d_data,
    input  logic [N-1:0]         s_d_corrupt,
    input  logic [N-1:0]         s_d_valid,
    output logic [N-1:0]         s_d_ready
);

    localparam int unsigned IDX_W  = $clog2(N);
    localparam int unsigned CNT_W  = $clog2(MAX_OUT + 1);
    localparam int unsigned HI_LSB = OFF_AW + IDX_W;

    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_GET         = 3'd4;
    localparam logic [2:0] OP_ACK         = 3'd0;
    localparam logic [2:0] OP_ACK_DATA    = 3'd1;

    typedef struct packed {
        logic [2:0]        opcode;
        logic [2:0]        param;
        logic [3:0]        size;
        logic [TL_RS-1:0]  source;
        logic [OFF_AW-1:0] offset;
        logic [3:0]        mask;
        logic [31:0]       data;
    } a_req_t;

    // err set selects the local error responder; idx is then don't-care (kept 0)
    typedef struct packed {
        logic             err;
        logic [IDX_W-1:0] idx;
    } tgt_t;

    a_req_t           a_req;
    tgt_t             a_tgt;
    logic             a_full;
    tgt_t             cur_tgt;
    logic [CNT_W-1:0] outstanding;

    logic             e_valid;
    logic [2:0]       e_opcode;
    logic [3:0]       e_size;
    logic [TL_RS-1:0] e_source;
    logic             e_corrupt;

    tgt_t dec_tgt;
    tgt_t ref_tgt;
    logic dec_mapped;
    logic room;
    logic has_out;
    logic busy;
    logic e_ready;
    logic a_fire;
    logic m_a_fire;
    logic m_d_fire;

    logic [2:0]       sd_opcode  [N];
    logic [1:0]       sd_param   [N];
    logic [3:0]       sd_size    [N];
    logic [TL_RS-1:0] sd_source  [N];
    logic [31:0]      sd_data    [N];

    // Address decode of the incoming master request
    always_comb begin
        dec_mapped  = (m_a_address[TL_AW-1:HI_LSB] == '0);
        dec_tgt.err = ~dec_mapped;
        dec_tgt.idx = dec_mapped ? m_a_address[OFF_AW +: IDX_W] : '0;
    end

    // Issue and acceptance control; ready never depends on this cycle's D fire
    always_comb begin
        room    = (outstanding != CNT_W'(MAX_OUT));
        has_out = (outstanding != '0);
        busy    = a_full | has_out;
        ref_tgt = a_full ? a_tgt : cur_tgt;
        e_ready = ~e_valid;
        a_fire  = a_full & room & (a_tgt.err ? e_ready : s_a_ready[a_tgt.idx]);
        m_a_ready = ~xbar_reset_i & (~a_full | a_fire) & room &
                    ~(busy & (dec_tgt != ref_tgt));
        m_a_fire  = m_a_valid & m_a_ready;
    end

    // Slave A channel: held payload broadcast, one-hot valid
    always_comb begin
        s_a_opcode  = a_req.opcode;
        s_a_param   = a_req.param;
        s_a_size    = a_req.size;
        s_a_source  = a_req.source;
        s_a_mask    = a_req.mask;
        s_a_data    = a_req.data;
        s_a_address = a_req.offset;
        for (int k = 0; k < N; k++) begin
            s_a_valid[k] = a_full & room & ~a_tgt.err & (a_tgt.idx == IDX_W'(k));
        end
    end

    // Unflatten slave D payloads
    always_comb begin
        for (int k = 0; k < N; k++) begin
            sd_opcode[k] = s_d_opcode[k*3 +: 3];
            sd_param[k]  = s_d_param[k*2 +: 2];
            sd_size[k]   = s_d_size[k*4 +: 4];
            sd_source[k] = s_d_source[k*TL_RS +: TL_RS];
            sd_data[k]   = s_d_data[k*32 +: 32];
        end
    end

    // D mux from the current target; nothing is presented with no request in flight
    always_comb begin
        m_d_opcode  = e_opcode;
        m_d_param   = 2'd0;
        m_d_size    = e_size;
        m_d_source  = e_source;
        m_d_denied  = 1'b1;
        m_d_data    = 32'd0;
        m_d_corrupt = e_corrupt;
        m_d_valid   = has_out & e_valid;
        if (!cur_tgt.err) begin
            m_d_opcode  = sd_opcode[cur_tgt.idx];
            m_d_param   = sd_param[cur_tgt.idx];
            m_d_size    = sd_size[cur_tgt.idx];
            m_d_source  = sd_source[cur_tgt.idx];
            m_d_denied  = s_d_denied[cur_tgt.idx];
            m_d_data    = sd_data[cur_tgt.idx];
            m_d_corrupt = s_d_corrupt[cur_tgt.idx];
            m_d_valid   = has_out & s_d_valid[cur_tgt.idx];
        end
        m_d_fire = m_d_valid & m_d_ready;
        for (int k = 0; k < N; k++) begin
            s_d_ready[k] = m_d_ready & has_out & ~cur_tgt.err & (cur_tgt.idx == IDX_W'(k));
        end
    end

    // A register, target tracking, outstanding count and error responder
    always_ff @(posedge xbar_clock_i) begin
        if (xbar_reset_i) begin
            a_full      <= 1'b0;
            a_req       <= '0;
            a_tgt       <= '0;
            cur_tgt     <= '0;
            outstanding <= '0;
            e_valid     <= 1'b0;
            e_opcode    <= 3'd0;
            e_size      <= 4'd0;
            e_source    <= '0;
            e_corrupt   <= 1'b0;
        end else begin
            if (m_a_fire) begin
                a_full       <= 1'b1;
                a_req.opcode <= m_a_opcode;
                a_req.param  <= m_a_param;
                a_req.size   <= m_a_size;
                a_req.source <= m_a_source;
                a_req.offset <= m_a_address[OFF_AW-1:0];
                a_req.mask   <= m_a_mask;
                a_req.data   <= m_a_data;
                a_tgt        <= dec_tgt;
            end else if (a_fire) begin
                a_full <= 1'b0;
            end

            if (a_fire) begin
                cur_tgt <= a_tgt;
            end

            if (a_fire && !m_d_fire) begin
                outstanding <= outstanding + CNT_W'(1);
            end else if (!a_fire && m_d_fire) begin
                outstanding <= outstanding - CNT_W'(1);
            end

            if (a_fire && a_tgt.err) begin
                e_valid  <= 1'b1;
                e_size   <= a_req.size;
                e_source <= a_req.source;
                if (a_req.opcode == OP_GET) begin
                    e_opcode  <= OP_ACK_DATA;
                    e_corrupt <= 1'b1;
                end else if (a_req.opcode == OP_PUT_FULL || a_req.opcode == OP_PUT_PARTIAL) begin
                    e_opcode  <= OP_ACK;
                    e_corrupt <= 1'b0;
                end else begin
                    e_opcode  <= OP_ACK;
                    e_corrupt <= 1'b0;
                end
            end else if (m_d_fire && cur_tgt.err) begin
                e_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tl_periph_demux.sv
// Directed self-checking bench for tl_periph_demux (N=4, OFF_AW=1, MAX_OUT=4).
// The bench plays both master and slaves with hand-sequenced vectors.
module tb_tl_periph_demux;

    localparam int unsigned TL_RS   = 4;
    localparam int unsigned TL_AW   = 32;
    localparam int unsigned N       = 4;
    localparam int unsigned OFF_AW  = 1;
    localparam int unsigned MAX_OUT = 4;

    logic                 clk;
    logic                 rst;
    logic [2:0]           m_a_opcode;
    logic [2:0]           m_a_param;
    logic [3:0]           m_a_size;
    logic [TL_RS-1:0]     m_a_source;
    logic [TL_AW-1:0]     m_a_address;
    logic [3:0]           m_a_mask;
    logic [31:0]          m_a_data;
    logic                 m_a_valid;
    logic                 m_a_ready;
    logic [2:0]           m_d_opcode;
    logic [1:0]           m_d_param;
    logic [3:0]           m_d_size;
    logic [TL_RS-1:0]     m_d_source;
    logic                 m_d_denied;
    logic [31:0]          m_d_data;
    logic                 m_d_corrupt;
    logic                 m_d_valid;
    logic                 m_d_ready;
    logic [2:0]           s_a_opcode;
    logic [2:0]           s_a_param;
    logic [3:0]           s_a_size;
    logic [TL_RS-1:0]     s_a_source;
    logic [3:0]           s_a_mask;
    logic [31:0]          s_a_data;
    logic [OFF_AW-1:0]    s_a_address;
    logic [N-1:0]         s_a_valid;
    logic [N-1:0]         s_a_ready;
    logic [N*3-1:0]       s_d_opcode;
    logic [N*2-1:0]       s_d_param;
    logic [N*4-1:0]       s_d_size;
    logic [N*TL_RS-1:0]   s_d_source;
    logic [N-1:0]         s_d_denied;
    logic [N*32-1:0]      s_d_data;
    logic [N-1:0]         s_d_corrupt;
    logic [N-1:0]         s_d_valid;
    logic [N-1:0]         s_d_ready;

    int errors = 0;
    int checks = 0;

    tl_periph_demux #(
        .TL_RS(TL_RS), .TL_AW(TL_AW), .N(N), .OFF_AW(OFF_AW), .MAX_OUT(MAX_OUT)
    ) dut (
        .xbar_clock_i(clk),      .xbar_reset_i(rst),
        .m_a_opcode(m_a_opcode), .m_a_param(m_a_param),     .m_a_size(m_a_size),
        .m_a_source(m_a_source), .m_a_address(m_a_address), .m_a_mask(m_a_mask),
        .m_a_data(m_a_data),     .m_a_valid(m_a_valid),     .m_a_ready(m_a_ready),
        .m_d_opcode(m_d_opcode), .m_d_param(m_d_param),     .m_d_size(m_d_size),
        .m_d_source(m_d_source), .m_d_denied(m_d_denied),   .m_d_data(m_d_data),
        .m_d_corrupt(m_d_corrupt), .m_d_valid(m_d_valid),   .m_d_ready(m_d_ready),
        .s_a_opcode(s_a_opcode), .s_a_param(s_a_param),     .s_a_size(s_a_size),
        .s_a_source(s_a_source), .s_a_mask(s_a_mask),       .s_a_data(s_a_data),
        .s_a_address(s_a_address), .s_a_valid(s_a_valid),  .s_a_ready(s_a_ready),
        .s_d_opcode(s_d_opcode), .s_d_param(s_d_param),     .s_d_size(s_d_size),
        .s_d_source(s_d_source), .s_d_denied(s_d_denied),   .s_d_data(s_d_data),
        .s_d_corrupt(s_d_corrupt), .s_d_valid(s_d_valid),   .s_d_ready(s_d_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then changed between edges
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_a(input logic vld, input logic [2:0] op, input logic [31:0] addr,
                           input logic [3:0] src, input logic [31:0] data);
        m_a_valid   = vld;
        m_a_opcode  = op;
        m_a_param   = 3'd0;
        m_a_size    = 4'd2;
        m_a_source  = src;
        m_a_address = addr;
        m_a_mask    = 4'hf;
        m_a_data    = data;
    endtask

    task automatic drive_d(input int k, input logic vld, input logic [2:0] op,
                           input logic [3:0] src, input logic [31:0] data);
        s_d_valid[k]            = vld;
        s_d_opcode[k*3 +: 3]    = op;
        s_d_param[k*2 +: 2]     = 2'd0;
        s_d_size[k*4 +: 4]      = 4'd2;
        s_d_source[k*4 +: 4]    = src;
        s_d_denied[k]           = 1'b0;
        s_d_data[k*32 +: 32]    = data;
        s_d_corrupt[k]          = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive_a(1'b1, 3'd4, 32'h0, 4'd0, 32'h0);
        m_d_ready   = 1'b0;
        s_a_ready   = '0;
        s_d_opcode  = '0;
        s_d_param   = '0;
        s_d_size    = '0;
        s_d_source  = '0;
        s_d_denied  = '0;
        s_d_data    = '0;
        s_d_corrupt = '0;
        s_d_valid   = '0;

        // Reset state
        tick(); tick(); tick();
        chk("rst_m_a_ready", m_a_ready, 1'b0);
        chk("rst_s_a_valid", s_a_valid, 4'b0000);
        chk("rst_m_d_valid", m_d_valid, 1'b0);
        chk("rst_s_d_ready", s_d_ready, 4'b0000);
        m_a_valid = 1'b0;
        rst = 1'b0;
        settle();
        chk("post_rst_m_a_ready", m_a_ready, 1'b1);

        // Put to slave 0 cfg
        tick();
        drive_a(1'b1, 3'd0, 32'h0, 4'd3, 32'h0000_0005);
        s_a_ready = 4'b0001;
        m_d_ready = 1'b1;
        settle();
        chk("put0_m_a_ready", m_a_ready, 1'b1);
        tick();
        m_a_valid = 1'b0;
        settle();
        chk("put0_s_a_valid", s_a_valid, 4'b0001);
        chk("put0_s_a_addr", s_a_address, 1'b0);
        chk("put0_s_a_data", s_a_data, 32'h5);
        chk("put0_s_a_src", s_a_source, 4'd3);
        chk("put0_s_a_op", s_a_opcode, 3'd0);
        tick();
        drive_d(0, 1'b1, 3'd0, 4'd3, 32'h0);
        settle();
        chk("put0_s_a_valid_gone", s_a_valid, 4'b0000);
        chk("put0_m_d_valid", m_d_valid, 1'b1);
        chk("put0_m_d_op", m_d_opcode, 3'd0);
        chk("put0_m_d_denied", m_d_denied, 1'b0);
        chk("put0_m_d_src", m_d_source, 4'd3);
        chk("put0_s_d_ready", s_d_ready, 4'b0001);
        tick();
        drive_d(0, 1'b0, 3'd0, 4'd0, 32'h0);
        settle();
        chk("put0_m_d_idle", m_d_valid, 1'b0);

        // Get slave 1 offset 1 with slave A backpressure
        drive_a(1'b1, 3'd4, 32'h3, 4'd5, 32'h0);
        s_a_ready = 4'b0000;
        settle();
        chk("get1_m_a_ready", m_a_ready, 1'b1);
        tick();
        m_a_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("get1_hold_valid", s_a_valid, 4'b0010);
            chk("get1_hold_addr", s_a_address, 1'b1);
            chk("get1_hold_op", s_a_opcode, 3'd4);
            chk("get1_hold_src", s_a_source, 4'd5);
            tick();
        end
        s_a_ready = 4'b0010;
        settle();
        chk("get1_fire_valid", s_a_valid, 4'b0010);
        tick();
        drive_d(1, 1'b1, 3'd1, 4'd5, 32'h0000_0002);
        settle();
        chk("get1_m_d_valid", m_d_valid, 1'b1);
        chk("get1_m_d_op", m_d_opcode, 3'd1);
        chk("get1_m_d_data", m_d_data, 32'h2);
        chk("get1_m_d_src", m_d_source, 4'd5);
        tick();
        drive_d(1, 1'b0, 3'd0, 4'd0, 32'h0);

        // Unmapped Get answered by the error responder
        drive_a(1'b1, 3'd4, 32'h8, 4'd7, 32'h0);
        s_a_ready = 4'b1111;
        settle();
        chk("err_get_m_a_ready", m_a_ready, 1'b1);
        tick();
        m_a_valid = 1'b0;
        settle();
        chk("err_get_s_a_valid", s_a_valid, 4'b0000);
        chk("err_get_early_d", m_d_valid, 1'b0);
        tick();
        settle();
        chk("err_get_m_d_valid", m_d_valid, 1'b1);
        chk("err_get_op", m_d_opcode, 3'd1);
        chk("err_get_denied", m_d_denied, 1'b1);
        chk("err_get_corrupt", m_d_corrupt, 1'b1);
        chk("err_get_data", m_d_data, 32'h0);
        chk("err_get_src", m_d_source, 4'd7);
        chk("err_get_size", m_d_size, 4'd2);
        chk("err_get_s_d_ready", s_d_ready, 4'b0000);
        tick();
        settle();
        chk("err_get_drained", m_d_valid, 1'b0);

        // Unmapped PutPartial
        drive_a(1'b1, 3'd1, 32'h10, 4'd4, 32'hdead_beef);
        tick();
        m_a_valid = 1'b0;
        tick();
        settle();
        chk("err_put_m_d_valid", m_d_valid, 1'b1);
        chk("err_put_op", m_d_opcode, 3'd0);
        chk("err_put_denied", m_d_denied, 1'b1);
        chk("err_put_corrupt", m_d_corrupt, 1'b0);
        chk("err_put_src", m_d_source, 4'd4);
        tick();

        // Target switch stalls until the previous target drains
        drive_a(1'b1, 3'd0, 32'h0, 4'd1, 32'h11);
        settle();
        chk("sw_put0_ready", m_a_ready, 1'b1);
        tick();
        drive_a(1'b1, 3'd0, 32'h4, 4'd2, 32'h22);
        settle();
        chk("sw_put2_blocked", m_a_ready, 1'b0);
        chk("sw_put0_issue", s_a_valid, 4'b0001);
        tick();
        for (int i = 0; i < 6; i++) begin
            settle();
            chk("sw_stall_ready", m_a_ready, 1'b0);
            chk("sw_stall_s_a", s_a_valid, 4'b0000);
            tick();
        end
        drive_d(0, 1'b1, 3'd0, 4'd1, 32'h0);
        settle();
        chk("sw_d0_valid", m_d_valid, 1'b1);
        chk("sw_d0_src", m_d_source, 4'd1);
        chk("sw_d0_ready_blk", m_a_ready, 1'b0);
        tick();
        drive_d(0, 1'b0, 3'd0, 4'd0, 32'h0);
        settle();
        chk("sw_put2_ready", m_a_ready, 1'b1);
        tick();
        m_a_valid = 1'b0;
        settle();
        chk("sw_put2_issue", s_a_valid, 4'b0100);
        chk("sw_put2_addr", s_a_address, 1'b0);
        chk("sw_put2_data", s_a_data, 32'h22);
        tick();
        drive_d(2, 1'b1, 3'd0, 4'd2, 32'h0);
        settle();
        chk("sw_d2_valid", m_d_valid, 1'b1);
        chk("sw_d2_src", m_d_source, 4'd2);
        tick();
        drive_d(2, 1'b0, 3'd0, 4'd0, 32'h0);

        // Outstanding limit: 6 Gets to slave 3 with D held off
        m_d_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_a(1'b1, 3'd4, 32'h6, 4'(i), 32'h0);
            settle();
            chk("lim_accept_ready", m_a_ready, 1'b1);
            tick();
        end
        drive_a(1'b1, 3'd4, 32'h6, 4'd5, 32'h0);
        settle();
        chk("lim_full_ready", m_a_ready, 1'b0);
        chk("lim_full_s_a", s_a_valid, 4'b0000);
        drive_d(3, 1'b1, 3'd1, 4'd0, 32'h30);
        tick();
        settle();
        chk("lim_hold_ready", m_a_ready, 1'b0);
        chk("lim_hold_d_valid", m_d_valid, 1'b1);
        m_d_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            drive_d(3, 1'b1, 3'd1, 4'(j), 32'h30 + 32'(j));
            settle();
            chk("lim_drain_valid", m_d_valid, 1'b1);
            chk("lim_drain_src", m_d_source, 4'(j));
            chk("lim_drain_data", m_d_data, 32'h30 + 32'(j));
            if (j == 0) chk("lim_drain_ready0", m_a_ready, 1'b0);
            if (j == 1) chk("lim_drain_ready1", m_a_ready, 1'b1);
            tick();
            if (j == 1) m_a_valid = 1'b0;
        end
        drive_d(3, 1'b0, 3'd0, 4'd0, 32'h0);
        settle();
        chk("lim_done_d", m_d_valid, 1'b0);
        chk("lim_done_s_a", s_a_valid, 4'b0000);

        // Reset with two outstanding and the A register full
        m_d_ready = 1'b0;
        s_a_ready = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            drive_a(1'b1, 3'd4, 32'h6, 4'(8 + i), 32'h0);
            tick();
        end
        m_a_valid = 1'b0;
        s_a_ready = 4'b0000;
        drive_d(3, 1'b1, 3'd1, 4'd8, 32'h0);
        settle();
        chk("mid_s_a_full", s_a_valid, 4'b1000);
        chk("mid_d_pending", m_d_valid, 1'b1);
        rst = 1'b1;
        tick();
        settle();
        chk("mid_rst_s_a", s_a_valid, 4'b0000);
        chk("mid_rst_m_d", m_d_valid, 1'b0);
        chk("mid_rst_s_d_ready", s_d_ready, 4'b0000);
        chk("mid_rst_m_a_ready", m_a_ready, 1'b0);
        rst = 1'b0;
        drive_d(3, 1'b0, 3'd0, 4'd0, 32'h0);
        settle();
        chk("mid_rel_m_a_ready", m_a_ready, 1'b1);
        drive_a(1'b1, 3'd0, 32'h2, 4'd9, 32'h99);
        s_a_ready = 4'b0010;
        m_d_ready = 1'b1;
        tick();
        m_a_valid = 1'b0;
        settle();
        chk("mid_new_s_a", s_a_valid, 4'b0010);
        chk("mid_new_data", s_a_data, 32'h99);
        tick();
        drive_d(1, 1'b1, 3'd0, 4'd9, 32'h0);
        settle();
        chk("mid_new_d_valid", m_d_valid, 1'b1);
        chk("mid_new_d_src", m_d_source, 4'd9);
        chk("mid_new_s_d_ready", s_d_ready, 4'b0010);
        tick();
        drive_d(1, 1'b0, 3'd0, 4'd0, 32'h0);
        settle();
        chk("mid_new_idle", m_d_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
